// File: rtl/ysyx_25060166_regfile_mp_pkg.sv
// ysyx_25060166_regfile_mp_pkg: shared sizing constants for the multi-port register file
package ysyx_25060166_regfile_mp_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_NUM  = 16;
    localparam int X0       = 0;

endpackage

// File: rtl/ysyx_25060166_regfile_wsel.sv
// ysyx_25060166_regfile_wsel: picks the winning write port for one register index
module ysyx_25060166_regfile_wsel
    import ysyx_25060166_regfile_mp_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NW   = 2,
    parameter int AW   = 4
) (
    input  logic [NW-1:0]      wen,
    input  logic [NW*AW-1:0]   waddr,
    input  logic [NW*XLEN-1:0] wdata,
    input  logic [AW-1:0]      idx,
    output logic               hit,
    output logic [XLEN-1:0]    data
);

    // Ascending scan so the highest-index matching port overrides; x0 never hits
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < NW; i++) begin
            if (wen[i] && waddr[i*AW +: AW] == idx && idx != AW'(X0)) begin
                hit  = 1'b1;
                data = wdata[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ysyx_25060166_regfile_mp.sv
// ysyx_25060166_regfile_mp: multi-port register file with busy scoreboard and write bypass
module ysyx_25060166_regfile_mp
    import ysyx_25060166_regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = REG_NUM,
    parameter int NR     = 2,
    parameter int NW     = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NR*AW-1:0]   raddr,
    output logic [NR*XLEN-1:0] rdata,
    output logic [NR-1:0]      rbusy,
    input  logic [NW-1:0]      wen,
    input  logic [NW*AW-1:0]   waddr,
    input  logic [NW*XLEN-1:0] wdata,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rd,
    input  logic               flush,
    output logic [NREG-1:0]    busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wd   [NREG];
    logic [NREG-1:0] whit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    for (genvar r = 0; r < NREG; r++) begin : g_wsel
        ysyx_25060166_regfile_wsel #(.XLEN(XLEN), .NW(NW), .AW(AW)) u_wsel (
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .idx   (AW'(r)),
            .hit   (whit[r]),
            .data  (wd[r])
        );
    end

    // Register array: each register takes its winning write; x0 never hits so stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) if (whit[r]) regs[r] <= wd[r];
        end
    end

    // Next scoreboard: writes retire producers, a new issue re-reserves even if also written
    always_comb begin
        busy_nxt = busy & ~whit;
        if (issue_valid && issue_rd != AW'(X0)) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[X0] = 1'b0;
    end

    // Scoreboard state: flush discards every reservation and same-cycle issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= flush ? '0 : busy_nxt;
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            bh;
        logic [XLEN-1:0] bd;
        assign ra = raddr[i*AW +: AW];
        ysyx_25060166_regfile_wsel #(.XLEN(XLEN), .NW(NW), .AW(AW)) u_byp (
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .idx   (ra),
            .hit   (bh),
            .data  (bd)
        );
        assign rdata[i*XLEN +: XLEN] = (ra == AW'(X0)) ? '0 :
                                       (BYPASS != 0 && bh) ? bd : regs[ra];
        assign rbusy[i] = (BYPASS != 0 && bh && !(issue_valid && issue_rd == ra)) ? 1'b0 : busy[ra];
    end

endmodule
